// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the single-clock FIFO.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   DEF_PTR_W             : pointer width for the default depth (index bits + wrap bit)
//   ptr_w()               : same computation for an arbitrary depth
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH) + 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port RAM with a synchronous write port and a registered read port.
//   clk, reset_n : clock; async active-low reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata updates only when re is high
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end
endmodule

// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock FIFO, DEPTH x WIDTH, registered read data.
//   clk, reset_n : clock; async active-low reset
//   in, wr_en    : write data / request (dropped while full)
//   rd_en        : read request (ignored while empty)
//   full, empty  : status flags, combinational from the registered pointers
//   out          : registered read data, changes only on an accepted read
module async_fifo_core
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] out
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;

  // Extra MSB distinguishes full (same index, different lap) from empty.
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Read and write never hit the same entry in one accepted cycle:
  // equal indices mean empty (read blocked) or full (write blocked).
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_acc),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (in),
    .re      (rd_acc),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (out)
  );
endmodule

// File: tb/tb_async_fifo_core.sv
module tb_async_fifo_core;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in;
  logic       wr_en, rd_en;
  logic       full, empty;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;

  logic [7:0] d  [16];
  logic [7:0] d2 [16];
  logic [7:0] w  [32];

  async_fifo_core #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .wr_en(wr_en), .rd_en(rd_en),
    .full(full), .empty(empty), .out(out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; in = '0;
    #14;
    checks++;
    if ({empty, full, out} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b out=%h want 1 0 00", empty, full, out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      d[i] = 8'($urandom);
      in = d[i]; wr_en = 1'b1;
      step();
      checks++;
      if (empty !== 1'b0 || full !== (i == 15)) begin
        errors++;
        $display("FAIL fill[%0d]: empty=%b full=%b want 0 %b", i, empty, full, (i == 15));
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      in = ~d[i]; wr_en = 1'b1;
      step();
      checks++;
      if (full !== 1'b1 || empty !== 1'b0 || out !== 8'h00) begin
        errors++;
        $display("FAIL overflow[%0d]: full=%b empty=%b out=%h want 1 0 00", i, full, empty, out);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      checks++;
      if (out !== d[i] || empty !== (i == 15) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: out=%h empty=%b full=%b want %h %b 0", i, out, empty, full, d[i], (i == 15));
      end
    end
  endtask

  task automatic test_underflow_wrap();
    // rd_en still high from the drain
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out !== d[15] || empty !== 1'b1) begin
        errors++;
        $display("FAIL underflow[%0d]: out=%h empty=%b want %h 1", i, out, empty, d[15]);
      end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d2[i] = 8'(8'h30 + i * 7);
      in = d2[i]; wr_en = 1'b1;
      step();
      checks++;
      if (empty !== 1'b0 || full !== (i == 15) || out !== d[15]) begin
        errors++;
        $display("FAIL refill[%0d]: empty=%b full=%b out=%h want 0 %b %h", i, empty, full, out, (i == 15), d[15]);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      checks++;
      if (out !== d2[i] || empty !== (i == 15) || full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_drain[%0d]: out=%h empty=%b full=%b want %h %b 0", i, out, empty, full, d2[i], (i == 15));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 32; i++) w[i] = 8'(8'h81 + i * 3);
    for (int i = 0; i < 4; i++) begin
      in = w[i]; wr_en = 1'b1; step();
    end
    // 10 cycles read+write: occupancy stays 4, output in order
    for (int k = 0; k < 10; k++) begin
      in = w[4 + k]; wr_en = 1'b1; rd_en = 1'b1;
      step();
      checks++;
      if (out !== w[k] || empty !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("FAIL simul[%0d]: out=%h empty=%b full=%b want %h 0 0", k, out, empty, full, w[k]);
      end
    end
    rd_en = 1'b0;
    // holds w[10..13]; add w[14..25] to reach 16
    for (int i = 14; i < 26; i++) begin
      in = w[i]; wr_en = 1'b1; step();
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL simul_full: full=%b want 1", full);
    end
    in = 8'hEE; wr_en = 1'b1; rd_en = 1'b1;
    step();
    checks++;
    if (out !== w[10] || full !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL simul_at_full: out=%h full=%b empty=%b want %h 0 0", out, full, empty, w[10]);
    end
    wr_en = 1'b0;
    for (int i = 11; i < 26; i++) begin
      step();
      checks++;
      if (out !== w[i] || empty !== (i == 25)) begin
        errors++;
        $display("FAIL simul_drain[%0d]: out=%h empty=%b want %h %b", i, out, empty, w[i], (i == 25));
      end
    end
    // empty: write accepted, read ignored, no bypass
    in = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
    step();
    checks++;
    if (out !== w[25] || empty !== 1'b0) begin
      errors++;
      $display("FAIL simul_at_empty: out=%h empty=%b want %h 0", out, empty, w[25]);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (out !== 8'h5A || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_after_empty: out=%h empty=%b want 5a 1", out, empty);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in = 8'(8'h11 * (i + 1)); wr_en = 1'b1; step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (out !== 8'h11 || empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: out=%h empty=%b want 11 0", out, empty);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({empty, full, out} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: empty=%b full=%b out=%h want 1 0 00", empty, full, out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_discard: out=%h empty=%b want 00 1", out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
